// File: rtl/reg_writeback_pkg.sv
// Shared types and sizes for the register writeback path: entry struct,
// register-file geometry and the per-channel queue depth.
package reg_writeback_pkg;
    localparam int REG_ADDR_W    = 4;
    localparam int REG_DATA_W    = 32;
    localparam int NUM_REGS      = 16;
    localparam int WB_FIFO_DEPTH = 2;
    localparam logic [REG_ADDR_W-1:0] VGA_REG = 4'hF;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // One-hot register mask for an entry, zero when the entry is not live.
    function automatic logic [NUM_REGS-1:0] addr_mask(input logic [REG_ADDR_W-1:0] addr,
                                                       input logic live);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (live) m[addr] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/reg_writeback_fifo.sv
// Two-entry shift FIFO for one writeback channel; slot 0 is always the head.
// Entries and their valid bits are exposed so the top can build the pending mask.
module wb_fifo
    import reg_writeback_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                push,
    input  wb_entry_t                           wr_entry,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output wb_entry_t                           head,
    output wb_entry_t [WB_FIFO_DEPTH-1:0]       entries,
    output logic      [WB_FIFO_DEPTH-1:0]       valid
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid   <= '0;
            entries <= '0;
        end else if (push && pop) begin
            // Occupancy is unchanged: shift the tail forward and refill behind it.
            if (valid[1]) begin
                entries[0] <= entries[1];
                entries[1] <= wr_entry;
            end else begin
                entries[0] <= wr_entry;
            end
        end else if (pop) begin
            entries[0] <= entries[1];
            valid      <= {1'b0, valid[1]};
        end else if (push) begin
            if (!valid[0]) begin
                entries[0] <= wr_entry;
                valid      <= 2'b01;
            end else begin
                entries[1] <= wr_entry;
                valid      <= 2'b11;
            end
        end
    end

    assign full  = valid[1];
    assign empty = !valid[0];
    assign head  = entries[0];
endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: two queued channels (ALU, loads) merged round-robin into
// the register-bank write port. Optional write counter under WB_STATS_EN.
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [REG_DATA_W-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [REG_DATA_W-1:0] b_data,
    input  logic                  flush,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] wa3,
    output logic [REG_DATA_W-1:0] wd3,
    output logic [NUM_REGS-1:0]   pend,
    output logic                  vga_upd
`ifdef WB_STATS_EN
    ,
    output logic [15:0]           wr_count
`endif
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic      a_full, a_empty, b_full, b_empty;
    logic      a_push, b_push, a_pop, b_pop;
    wb_entry_t a_head, b_head, out_entry;
    wb_entry_t [WB_FIFO_DEPTH-1:0] a_entries, b_entries;
    logic      [WB_FIFO_DEPTH-1:0] a_vld, b_vld;
    logic [0:0] state;
    grant_t    last_grant;

    assign a_ready = !a_full && !flush && !rst;
    assign b_ready = !b_full && !flush && !rst;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    // A wins when B is idle or B had the previous grant.
    assign a_pop = !a_empty && (b_empty || last_grant == GRANT_B);
    assign b_pop = !b_empty && !a_pop;

    wb_fifo u_fifo_a (
        .clk(clk), .rst(rst), .clear(flush),
        .push(a_push), .wr_entry('{addr: a_addr, data: a_data}), .pop(a_pop),
        .full(a_full), .empty(a_empty), .head(a_head),
        .entries(a_entries), .valid(a_vld)
    );

    wb_fifo u_fifo_b (
        .clk(clk), .rst(rst), .clear(flush),
        .push(b_push), .wr_entry('{addr: b_addr, data: b_data}), .pop(b_pop),
        .full(b_full), .empty(b_empty), .head(b_head),
        .entries(b_entries), .valid(b_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_entry  <= '0;
            last_grant <= GRANT_B;
        end else if (flush) begin
            state     <= IDLE;
            out_entry <= '0;
        end else if (a_pop) begin
            state      <= WRITE;
            out_entry  <= a_head;
            last_grant <= GRANT_A;
        end else if (b_pop) begin
            state      <= WRITE;
            out_entry  <= b_head;
            last_grant <= GRANT_B;
        end else begin
            state <= IDLE;
        end
    end

    assign we3     = (state == WRITE);
    assign wa3     = out_entry.addr;
    assign wd3     = out_entry.data;
    assign vga_upd = we3 && (out_entry.addr == VGA_REG);

    always_comb begin
        pend = addr_mask(out_entry.addr, we3);
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            pend = pend | addr_mask(a_entries[i].addr, a_vld[i])
                        | addr_mask(b_entries[i].addr, b_vld[i]);
        end
    end

`ifdef WB_STATS_EN
    // Survives flush on purpose: it counts writes that actually reached the bank.
    always_ff @(posedge clk) begin
        if (rst)      wr_count <= '0;
        else if (we3) wr_count <= wr_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model. Define WB_STATS_EN to cover wr_count.
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [3:0]  a_addr, b_addr, wa3;
    logic [31:0] a_data, b_data, wd3;
    logic        we3, vga_upd;
    logic [15:0] pend;
`ifdef WB_STATS_EN
    logic [15:0] wr_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel queues of {addr,data}, one output slot.
    logic [35:0] qa[$];
    logic [35:0] qb[$];
    logic        m_out_v;
    logic [35:0] m_out;
    logic        m_last_b;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .flush(flush), .we3(we3), .wa3(wa3), .wd3(wd3),
        .pend(pend), .vga_upd(vga_upd)
`ifdef WB_STATS_EN
        , .wr_count(wr_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pend();
        logic [15:0] p;
        p = '0;
        foreach (qa[i]) p[qa[i][35:32]] = 1'b1;
        foreach (qb[i]) p[qb[i][35:32]] = 1'b1;
        if (m_out_v) p[m_out[35:32]] = 1'b1;
        return p;
    endfunction

    task automatic model_edge();
        logic acc_a, acc_b;
        if (rst) m_cnt = '0;
        else if (m_out_v) m_cnt = m_cnt + 16'd1;
        if (rst) begin
            qa.delete(); qb.delete();
            m_out_v = 1'b0; m_out = '0; m_last_b = 1'b1;
        end else if (flush) begin
            qa.delete(); qb.delete();
            m_out_v = 1'b0;
        end else begin
            acc_a = a_valid && (qa.size() < 2);
            acc_b = b_valid && (qb.size() < 2);
            m_out_v = 1'b0;
            if (qa.size() > 0 && (qb.size() == 0 || m_last_b)) begin
                m_out = qa.pop_front(); m_out_v = 1'b1; m_last_b = 1'b0;
            end else if (qb.size() > 0) begin
                m_out = qb.pop_front(); m_out_v = 1'b1; m_last_b = 1'b1;
            end
            if (acc_a) qa.push_back({a_addr, a_data});
            if (acc_b) qb.push_back({b_addr, b_data});
        end
    endtask

    // One clock: drive inputs, compare outputs mid-cycle, then advance the model.
    task automatic cyc(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [31:0] bd,
                       input logic fl, input logic r);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        flush = fl; rst = r;
        #1;
        chk("a_ready", 32'(a_ready), 32'(!r && !fl && qa.size() < 2));
        chk("b_ready", 32'(b_ready), 32'(!r && !fl && qb.size() < 2));
        chk("we3", 32'(we3), 32'(m_out_v));
        chk("pend", 32'(pend), 32'(model_pend()));
        chk("vga_upd", 32'(vga_upd), 32'(m_out_v && m_out[35:32] == 4'hF));
        if (m_out_v) begin
            chk("wa3", 32'(wa3), 32'(m_out[35:32]));
            chk("wd3", wd3, m_out[31:0]);
        end
`ifdef WB_STATS_EN
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
`endif
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        m_out_v = 0; m_out = '0; m_last_b = 1'b1; m_cnt = '0;
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // Reset state
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        idle(1);

        // Single A push: pending one cycle, written two cycles after acceptance
        cyc(1, 4'd3, 32'h000000FF, 0, 0, 0, 0, 0);
        chk("lat_pend3", 32'(pend[3]), 32'd1);
        chk("lat_we3_early", 32'(we3), 32'd0);
        idle(4);

        // Contention: alternate A(1)/B(2), FIFOs fill and readies drop
        for (int i = 0; i < 8; i++) cyc(1, 4'd1, $urandom, 1, 4'd2, $urandom, 0, 0);
        idle(6);

        // VGA register update
        cyc(0, 0, 0, 1, 4'hF, 32'hDEADBEEF, 0, 0);
        idle(4);

        // Fill then flush
        for (int i = 0; i < 4; i++) cyc(1, $urandom, $urandom, 1, $urandom, $urandom, 0, 0);
        cyc(1, 4'd5, 32'h55, 1, 4'd6, 32'h66, 1, 0);
        idle(4);

        // Reset while full, then a single write to r0
        for (int i = 0; i < 4; i++) cyc(1, $urandom, $urandom, 1, $urandom, $urandom, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 4'd0, 32'h12345678, 0, 0, 0, 0, 0);
        idle(4);

        // Same address from both channels
        cyc(1, 4'd7, 32'hAAAA0001, 1, 4'd7, 32'hBBBB0002, 0, 0);
        idle(4);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 60, $urandom, $urandom,
                $urandom_range(0, 99) < 60, $urandom, $urandom,
                $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
        idle(4);

`ifdef WB_STATS_EN
        force dut.wr_count = 16'hFFFF;
        #1;
        release dut.wr_count;
        m_cnt = 16'hFFFF;
        cyc(1, 4'd9, 32'h9, 0, 0, 0, 0, 0);
        idle(3);
        chk("wr_count_wrap", 32'(wr_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: a_valid input 1, a_ready output 1, a_addr input 4, a_data input 32: channel A (ALU results), valid/ready.
REQ-004 SHALL have ports: b_valid input 1, b_ready output 1, b_addr input 4, b_data input 32: channel B (memory loads), valid/ready.
REQ-005 SHALL have port: flush  input  1  discard all queued and in-flight writes.
REQ-006 SHALL have ports: we3 output 1, wa3 output 4, wd3 output 32: Reg_bank write port.
REQ-007 SHALL have port: pend  output 16  bit i high while any accepted write to register i has not yet reached the write port.
REQ-008 SHALL have port: vga_upd  output 1  one-cycle pulse coincident with a we3 write to register 15.

Function
REQ-009 Each channel SHALL own a 2-entry FIFO; a transfer occurs when valid and ready are both high at a rising edge.
REQ-010 x_ready SHALL equal (FIFO not full) and not flush; a full FIFO popped in the same cycle still shows ready low.
REQ-011 The arbiter SHALL pop at most one FIFO head per cycle into a single output register; the output register SHALL be free every cycle, because the register bank never stalls.
REQ-012 With one head valid, the arbiter SHALL pop that FIFO; with both valid, it SHALL pop the channel not granted last (round-robin), and last_grant SHALL start at B so that A wins first.
REQ-013 The output state machine SHALL have IDLE (we3=0) and WRITE (we3=1, wa3/wd3 from the output register); it enters WRITE on a pop and returns to IDLE otherwise.
REQ-014 Latency SHALL be 2 cycles: an entry accepted at edge N into an empty FIFO, with no contention, drives we3 during the cycle after edge N+1.
REQ-015 An accepted entry SHALL be written exactly once; entries within a channel SHALL be written in acceptance order.
REQ-016 pend SHALL be computed from valid FIFO entries plus the output register while we3 is high; it is combinational from state.
REQ-017 Simultaneous push and pop on one FIFO SHALL be legal, and its occupancy SHALL stay unchanged.
REQ-018 flush high at an edge SHALL empty both FIFOs and the output register, giving we3=0 and pend=0 in the next cycle; inputs presented in the flush cycle SHALL NOT be accepted.
REQ-019 Two queued writes to the same address from different channels SHALL both be issued, in arbitration order.

Reset
REQ-020 rst SHALL clear both FIFOs and the output register and set last_grant=B; after the reset edge: we3=0, wa3=0, wd3=0, pend=0, vga_upd=0, a_ready=b_ready=0 while rst is high, and 1 after release.
REQ-021 rst asserted mid-operation SHALL drop all queued writes without issuing them.

Configuration
REQ-022 With macro WB_STATS_EN defined, the block SHALL add output wr_count (16 bits), which increments on every cycle with we3=1, wraps from 0xFFFF to 0, and clears on rst (not on flush).
REQ-023 Without WB_STATS_EN, the wr_count port and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-024 A shared package SHALL hold: REG_ADDR_W=4, REG_DATA_W=32, NUM_REGS=16, VGA_REG=4'hF, WB_FIFO_DEPTH=2, and the typedef wb_entry_t {addr, data}.
REQ-025 A sub-module wb_fifo (2-entry, push/pop/full/empty, entries exposed for pend) SHALL be instantiated once per channel.

Verification
REQ-026 Release reset, then push A(addr 3, 0x000000FF) once -> we3=1, wa3=3, wd3=0xFF exactly 2 cycles later; pend[3] high in between.
REQ-027 Both channels valid every cycle, A addr 1 and B addr 2 -> writes alternate 1,2,1,2 starting with A; both readies fall once the FIFOs are full.
REQ-028 Push B(addr 15, 0xDEADBEEF) -> vga_upd=1 in the same cycle as we3=1 with wa3=15; vga_upd=0 otherwise.
REQ-029 Fill both FIFOs, then pulse flush -> no further we3, pend=0 in the next cycle, and the write bank is unchanged.
REQ-030 Assert rst while both FIFOs are full -> no write is issued; after release a single push to addr 0 is written after 2 cycles.
REQ-031 With WB_STATS_EN, after 5 writes wr_count=5; with the count preloaded to 0xFFFF by forcing, one more write gives wr_count=0.
